uart_rx_frame: RTL

Parametrised UART receiver, next generation of the team's fixed 8N1 receiver. Adds configurable data width, parity, stop-bit count, mid-bit majority sampling, a valid/ready output handshake with overrun detection, and framing, parity and break reporting. Sits between the pad-side `rxd` input and a byte/word stream consumer such as a FIFO or command parser.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/delay.sv | 28 ++
 rtl/uart_bit_sampler.sv | 69 ++++++
 rtl/uart_rx_frame.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types for the UART receive path.
// Holds the parity mode and receiver state encodings.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } rx_state_e;

    function automatic logic maj3(
        input logic a,
        input logic b,
        input logic c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/delay.sv
// delay: LENGTH-deep register chain, also used as a synchroniser.
// RST_VAL lets the chain reset to the line's idle level.
module delay #(
    parameter int              LENGTH  = 2,
    parameter int              WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] pipe_q [LENGTH];

    // shift the input through the chain
    always_ff @(posedge clk) begin
        if (!nrst) begin
            for (int i = 0; i < LENGTH; i++) pipe_q[i] <= RST_VAL;
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < LENGTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign q_o = pipe_q[LENGTH-1];

endmodule

// File: rtl/uart_bit_sampler.sv
// uart_bit_sampler: bit-period counter and sample point generation.
// UART_RX_MAJORITY_EN selects a 2-of-3 vote one cycle after the tick.
module uart_bit_sampler
    import uart_pkg::*;
#(
    parameter int D = 16
) (
    input  logic clk,
    input  logic nrst,
    input  logic run_i,
    input  logic rxd_i,
    output logic bit_strobe_o,
    output logic bit_val_o
);

    localparam int            CW  = $clog2(D);
    localparam logic [CW-1:0] RLD = CW'(D - 1);
    localparam logic [CW-1:0] HLD = CW'(D / 2 - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick;

    assign tick = run_i && (cnt_q == '0);

    // count down while a frame is in flight, park at half a bit otherwise
    always_comb begin
        cnt_d = cnt_q;
        if (!run_i) begin
            cnt_d = HLD;
        end else if (cnt_q == '0) begin
            cnt_d = RLD;
        end else begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // counter register
    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt_q <= HLD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic s1_q, s0_q, stb_q;

    // capture the samples around the tick; the third is the live line
    always_ff @(posedge clk) begin
        if (!nrst) begin
            s1_q  <= 1'b0;
            s0_q  <= 1'b0;
            stb_q <= 1'b0;
        end else begin
            if (cnt_q == CW'(1)) s1_q <= rxd_i;
            if (tick) s0_q <= rxd_i;
            stb_q <= tick;
        end
    end

    assign bit_strobe_o = stb_q;
    assign bit_val_o    = maj3(s1_q, s0_q, rxd_i);
`else
    assign bit_strobe_o = tick;
    assign bit_val_o    = rxd_i;
`endif

endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: parametrised UART receiver with valid/ready output.
// Optional macro UART_RX_MAJORITY_EN enables 2-of-3 bit voting.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = 200000000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_break,
    output logic                 rx_overrun,
    output logic                 rx_busy
);

    localparam int D = CLK_HZ / BAUD;

    if (D < 8) begin : g_bad_baud
        $error("uart_rx_frame: CLK_HZ/BAUD must be at least 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
        $error("uart_rx_frame: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_par
        $error("uart_rx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_rx_frame: STOP_BITS must be 1 or 2");
    end

    localparam parity_e       PMODE     = parity_e'(PARITY);
    localparam int            BW        = 4;
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    logic rxd_s;
    logic strobe;
    logic bval;
    logic run;

    rx_state_e            state_q, state_d;
    logic                 armed_q, armed_d;
    logic [BW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 one_q, one_d;
    logic                 done;

    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 pe_q, fe_q, brk_q, ovr_q;

    delay #(
        .LENGTH  (2),
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk  (clk),
        .nrst (nrst),
        .d_i  (rxd),
        .q_o  (rxd_s)
    );

    assign run = (state_q != IDLE);

    uart_bit_sampler #(
        .D (D)
    ) u_sampler (
        .clk          (clk),
        .nrst         (nrst),
        .run_i        (run),
        .rxd_i        (rxd_s),
        .bit_strobe_o (strobe),
        .bit_val_o    (bval)
    );

    // frame sequencing: start check, data shift, parity, stop bits
    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        one_d   = one_q;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rxd_s) armed_d = 1'b1;
                if (armed_q && !rxd_s) begin
                    state_d = START;
                    idx_d   = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                    one_d   = 1'b0;
                end
            end
            START: begin
                if (strobe) begin
                    state_d = bval ? IDLE : DATA;
                end
            end
            DATA: begin
                if (strobe) begin
                    shift_d = {bval, shift_q[DATA_BITS-1:1]};
                    one_d   = one_q | bval;
                    if (idx_q == LAST_DATA) begin
                        idx_d   = '0;
                        state_d = (PMODE != PAR_NONE) ? PAR : STOP;
                    end else begin
                        idx_d = idx_q + BW'(1);
                    end
                end
            end
            PAR: begin
                if (strobe) begin
                    one_d   = one_q | bval;
                    perr_d  = ((^shift_q) ^ bval) != (PMODE == PAR_ODD);
                    state_d = STOP;
                end
            end
            STOP: begin
                if (strobe) begin
                    ferr_d = ferr_q | !bval;
                    one_d  = one_q | bval;
                    if (idx_q == LAST_STOP) begin
                        done    = 1'b1;
                        idx_d   = '0;
                        armed_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + BW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // receiver state registers
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
            idx_q   <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            one_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            one_q   <= one_d;
        end
    end

    // output holding register with drop-on-full overrun
    always_ff @(posedge clk) begin
        if (!nrst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            brk_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (done && (!valid_q || rx_ready)) begin
                data_q  <= shift_q;
                pe_q    <= perr_q;
                fe_q    <= ferr_d;
                brk_q   <= !one_d;
                valid_q <= 1'b1;
            end else if (done) begin
                ovr_q <= 1'b1;
            end else if (valid_q && rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx_data       = data_q;
    assign rx_valid      = valid_q;
    assign rx_parity_err = pe_q;
    assign rx_frame_err  = fe_q;
    assign rx_break      = brk_q;
    assign rx_overrun    = ovr_q;
    assign rx_busy       = run;

endmodule
